pipelined_controller: RTL

Successor to the single-cycle controller, for the pipelined RV32I core. It decodes opcode/funct3/funct7b5 in the ID stage and holds the control word in an internal ID/EX register with stall and flush. In EX it resolves branch and jump direction from ALU flags, producing the PC-select signal the single-cycle version left out. It adds full RV32I ALU coverage (wider ALU control), LUI/AUIPC/JALR support, illegal-opcode detection and a saturating illegal-instruction counter.

---
 rtl/pipelined_controller.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/pipelined_controller.sv
// Pipelined RV32I control unit: ID-stage decode, ID/EX control register with
// stall/flush, EX-stage branch/jump resolution and illegal-opcode accounting.
module pipelined_controller #(
   parameter int ALUCTRL_W = 4,
   parameter int CNT_W     = 16
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic [6:0]           i_op,
   input  logic [2:0]           i_funct3,
   input  logic                 i_funct7b5,
   input  logic                 i_stall,
   input  logic                 i_flush,
   input  logic                 i_zero,
   input  logic                 i_lt,
   input  logic                 i_ltu,
   output logic [2:0]           o_immsrc,
   output logic [ALUCTRL_W-1:0] o_alucrtl,
   output logic                 o_alusrca,
   output logic                 o_alusrc,
   output logic [1:0]           o_resultsrc,
   output logic                 o_memwrite,
   output logic                 o_regwrite,
   output logic                 o_jump,
   output logic                 o_jalr,
   output logic                 o_branch,
   output logic                 o_pcsrc,
   output logic                 o_illegal,
   output logic [CNT_W-1:0]     o_illegal_cnt
);

   localparam logic [3:0] ALU_ADD  = 4'd0;
   localparam logic [3:0] ALU_SUB  = 4'd1;
   localparam logic [3:0] ALU_AND  = 4'd2;
   localparam logic [3:0] ALU_OR   = 4'd3;
   localparam logic [3:0] ALU_XOR  = 4'd4;
   localparam logic [3:0] ALU_SLT  = 4'd5;
   localparam logic [3:0] ALU_SLTU = 4'd6;
   localparam logic [3:0] ALU_SLL  = 4'd7;
   localparam logic [3:0] ALU_SRL  = 4'd8;
   localparam logic [3:0] ALU_SRA  = 4'd9;
   localparam logic [3:0] ALU_PASS = 4'd10;

   logic [3:0] f3_alu;
   logic [3:0] dec_alu;
   logic [2:0] dec_immsrc;
   logic [1:0] dec_resultsrc;
   logic       dec_alusrca, dec_alusrc, dec_memwrite, dec_regwrite;
   logic       dec_jump, dec_jalr, dec_branch, dec_illegal;
   logic [2:0] funct3_q;
   logic       take;
   logic       accept_illegal;

   always_comb begin
      f3_alu = ALU_ADD;
      case (i_funct3)
         3'b000:  f3_alu = ALU_ADD;
         3'b001:  f3_alu = ALU_SLL;
         3'b010:  f3_alu = ALU_SLT;
         3'b011:  f3_alu = ALU_SLTU;
         3'b100:  f3_alu = ALU_XOR;
         3'b101:  f3_alu = i_funct7b5 ? ALU_SRA : ALU_SRL;
         3'b110:  f3_alu = ALU_OR;
         3'b111:  f3_alu = ALU_AND;
         default: f3_alu = ALU_ADD;
      endcase
   end

   // Unknown or X opcodes fall to the default arm, so the word stays a clean bubble.
   always_comb begin
      dec_alu       = ALU_ADD;
      dec_immsrc    = 3'b000;
      dec_resultsrc = 2'b00;
      dec_alusrca   = 1'b0;
      dec_alusrc    = 1'b0;
      dec_memwrite  = 1'b0;
      dec_regwrite  = 1'b0;
      dec_jump      = 1'b0;
      dec_jalr      = 1'b0;
      dec_branch    = 1'b0;
      dec_illegal   = 1'b0;
      case (i_op)
         7'b0110011: begin
            dec_alu      = (i_funct3 == 3'b000 && i_funct7b5) ? ALU_SUB : f3_alu;
            dec_regwrite = 1'b1;
         end
         7'b0010011: begin
            dec_alu      = f3_alu;
            dec_alusrc   = 1'b1;
            dec_regwrite = 1'b1;
         end
         7'b0000011: begin
            dec_alusrc    = 1'b1;
            dec_resultsrc = 2'b01;
            dec_regwrite  = 1'b1;
         end
         7'b0100011: begin
            dec_alusrc   = 1'b1;
            dec_memwrite = 1'b1;
            dec_immsrc   = 3'b001;
         end
         7'b1100011: begin
            dec_alu    = ALU_SUB;
            dec_branch = 1'b1;
            dec_immsrc = 3'b010;
         end
         7'b1101111: begin
            dec_jump      = 1'b1;
            dec_resultsrc = 2'b10;
            dec_regwrite  = 1'b1;
            dec_immsrc    = 3'b011;
         end
         7'b1100111: begin
            dec_alusrc    = 1'b1;
            dec_jump      = 1'b1;
            dec_jalr      = 1'b1;
            dec_resultsrc = 2'b10;
            dec_regwrite  = 1'b1;
         end
         7'b0110111: begin
            dec_alu      = ALU_PASS;
            dec_immsrc   = 3'b100;
            dec_regwrite = 1'b1;
         end
         7'b0010111: begin
            dec_alusrca  = 1'b1;
            dec_alusrc   = 1'b1;
            dec_immsrc   = 3'b100;
            dec_regwrite = 1'b1;
         end
         default: dec_illegal = 1'b1;
      endcase
   end

   assign o_immsrc       = dec_immsrc;
   assign accept_illegal = dec_illegal & ~i_flush & ~i_stall;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         o_alucrtl     <= '0;
         o_alusrca     <= 1'b0;
         o_alusrc      <= 1'b0;
         o_resultsrc   <= 2'b00;
         o_memwrite    <= 1'b0;
         o_regwrite    <= 1'b0;
         o_jump        <= 1'b0;
         o_jalr        <= 1'b0;
         o_branch      <= 1'b0;
         funct3_q      <= 3'b000;
         o_illegal     <= 1'b0;
         o_illegal_cnt <= '0;
      end else begin
         if (i_flush) begin
            o_alucrtl   <= '0;
            o_alusrca   <= 1'b0;
            o_alusrc    <= 1'b0;
            o_resultsrc <= 2'b00;
            o_memwrite  <= 1'b0;
            o_regwrite  <= 1'b0;
            o_jump      <= 1'b0;
            o_jalr      <= 1'b0;
            o_branch    <= 1'b0;
            funct3_q    <= 3'b000;
         end else if (!i_stall) begin
            o_alucrtl   <= ALUCTRL_W'(dec_alu);
            o_alusrca   <= dec_alusrca;
            o_alusrc    <= dec_alusrc;
            o_resultsrc <= dec_resultsrc;
            o_memwrite  <= dec_memwrite;
            o_regwrite  <= dec_regwrite;
            o_jump      <= dec_jump;
            o_jalr      <= dec_jalr;
            o_branch    <= dec_branch;
            funct3_q    <= i_funct3;
         end
         o_illegal <= accept_illegal;
         if (accept_illegal && o_illegal_cnt != '1)
            o_illegal_cnt <= o_illegal_cnt + CNT_W'(1);
      end
   end

   always_comb begin
      take = 1'b0;
      case (funct3_q)
         3'b000:  take = i_zero;
         3'b001:  take = ~i_zero;
         3'b100:  take = i_lt;
         3'b101:  take = ~i_lt;
         3'b110:  take = i_ltu;
         3'b111:  take = ~i_ltu;
         default: take = 1'b0;
      endcase
   end

   assign o_pcsrc = o_jump | (o_branch & take);

endmodule
